// File: rtl/rv0_fetch.sv
// rv0 instruction fetch stage.
// Keeps the PC, issues one word request per grant, and holds fetched
// instructions with their addresses in an in-order queue that feeds the
// fetch-to-decode skid buffer over a rdy/ack handshake. A flush redirects the
// PC, empties the queue and arranges for in-flight responses to be dropped.
module rv0_fetch #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_addr_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [XLEN-1:0] addr_o,
    output logic [31:0]     insn_o,
    output logic            rdy_o,
    input  logic            ack_i
);

    localparam int unsigned     PW        = $clog2(DEPTH);
    localparam int unsigned     CW        = $clog2(DEPTH + 1);
    localparam logic [31:0]     NOP_INSN  = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);
    localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(32'd3));
    localparam logic [CW:0]     DEPTH_W   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [PW-1:0]   PTR_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0]   PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};

    // Architectural state
    logic [XLEN-1:0] pc_r, pc_nxt_s;
    logic [PW-1:0]   head_r, head_nxt_s;
    logic [PW-1:0]   tail_r, tail_nxt_s;
    logic [PW-1:0]   fill_r, fill_nxt_s;
    logic [CW-1:0]   alloc_r, alloc_nxt_s;
    logic [CW-1:0]   drop_r, drop_nxt_s;
    // Granted requests whose response has not arrived yet (kept or dropped);
    // this is what drop_cnt is reloaded from on a flush.
    logic [CW-1:0]   pend_r, pend_nxt_s;

    logic [XLEN-1:0] q_addr_r     [DEPTH];
    logic [XLEN-1:0] q_addr_nxt_s [DEPTH];
    logic [31:0]     q_insn_r     [DEPTH];
    logic [31:0]     q_insn_nxt_s [DEPTH];
    logic [DEPTH-1:0] q_filled_r, q_filled_nxt_s;

    // Registered outputs, computed from next state
    logic            req_r, req_nxt_s;
    logic            rdy_r, rdy_nxt_s;
    logic [XLEN-1:0] addr_r, addr_nxt_s;
    logic [31:0]     insn_r, insn_nxt_s;

    // Per-cycle events
    logic            grant_s;
    logic            pop_s;
    logic            rsp_ok_s;
    logic [CW-1:0]   grant_w_s;
    logic [CW-1:0]   pop_w_s;
    logic [CW-1:0]   rsp_w_s;
    logic [CW:0]     occ_nxt_s;

    assign grant_s   = req_r & imem_gnt_i;
    assign pop_s     = rdy_r & ack_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok_s  = imem_rvalid_i & (pend_r != CNT_ZERO);
    assign grant_w_s = {{(CW-1){1'b0}}, grant_s};
    assign pop_w_s   = {{(CW-1){1'b0}}, pop_s};
    assign rsp_w_s   = {{(CW-1){1'b0}}, rsp_ok_s};

    // Next-state computation for PC, queue, pointers, counters and outputs
    always_comb begin
        pc_nxt_s       = pc_r;
        head_nxt_s     = head_r;
        tail_nxt_s     = tail_r;
        fill_nxt_s     = fill_r;
        alloc_nxt_s    = alloc_r;
        drop_nxt_s     = drop_r;
        pend_nxt_s     = pend_r + grant_w_s - rsp_w_s;
        q_addr_nxt_s   = q_addr_r;
        q_insn_nxt_s   = q_insn_r;
        q_filled_nxt_s = q_filled_r;

        if (flush_i) begin
            // Everything still outstanding after this cycle belongs to the
            // old stream; a response arriving now is discarded with it.
            pc_nxt_s       = flush_addr_i & WORD_MASK;
            head_nxt_s     = PTR_ZERO;
            tail_nxt_s     = PTR_ZERO;
            fill_nxt_s     = PTR_ZERO;
            alloc_nxt_s    = CNT_ZERO;
            q_filled_nxt_s = {DEPTH{1'b0}};
            drop_nxt_s     = pend_r + grant_w_s - rsp_w_s;
        end else begin
            if (grant_s) begin
                q_addr_nxt_s[tail_r]   = pc_r;
                q_filled_nxt_s[tail_r] = 1'b0;
                tail_nxt_s             = tail_r + PTR_ONE;
                pc_nxt_s               = pc_r + PC_STEP;
            end else begin
                tail_nxt_s = tail_r;
            end

            if (rsp_ok_s && (drop_r != CNT_ZERO)) begin
                drop_nxt_s = drop_r - {{(CW-1){1'b0}}, 1'b1};
            end else if (rsp_ok_s) begin
                q_insn_nxt_s[fill_r]   = imem_rdata_i;
                q_filled_nxt_s[fill_r] = 1'b1;
                fill_nxt_s             = fill_r + PTR_ONE;
            end else begin
                fill_nxt_s = fill_r;
            end

            if (pop_s) begin
                head_nxt_s = head_r + PTR_ONE;
            end else begin
                head_nxt_s = head_r;
            end

            alloc_nxt_s = alloc_r + grant_w_s - pop_w_s;
        end

        occ_nxt_s  = {1'b0, alloc_nxt_s} + {1'b0, drop_nxt_s};
        req_nxt_s  = (occ_nxt_s < DEPTH_W);
        rdy_nxt_s  = (alloc_nxt_s != CNT_ZERO) & q_filled_nxt_s[head_nxt_s];
        addr_nxt_s = q_addr_nxt_s[head_nxt_s];
        insn_nxt_s = q_insn_nxt_s[head_nxt_s];
    end

    // State and output registers; asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_r       <= RESET_ADDR;
            head_r     <= PTR_ZERO;
            tail_r     <= PTR_ZERO;
            fill_r     <= PTR_ZERO;
            alloc_r    <= CNT_ZERO;
            drop_r     <= CNT_ZERO;
            pend_r     <= CNT_ZERO;
            q_filled_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                q_addr_r[i] <= {XLEN{1'b0}};
                q_insn_r[i] <= NOP_INSN;
            end
            req_r      <= 1'b0;
            rdy_r      <= 1'b0;
            addr_r     <= {XLEN{1'b0}};
            insn_r     <= NOP_INSN;
        end else begin
            pc_r       <= pc_nxt_s;
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            fill_r     <= fill_nxt_s;
            alloc_r    <= alloc_nxt_s;
            drop_r     <= drop_nxt_s;
            pend_r     <= pend_nxt_s;
            q_filled_r <= q_filled_nxt_s;
            q_addr_r   <= q_addr_nxt_s;
            q_insn_r   <= q_insn_nxt_s;
            req_r      <= req_nxt_s;
            rdy_r      <= rdy_nxt_s;
            addr_r     <= addr_nxt_s;
            insn_r     <= insn_nxt_s;
        end
    end

    assign imem_req_o  = req_r;
    assign imem_addr_o = pc_r;
    assign rdy_o       = rdy_r;
    assign addr_o      = addr_r;
    assign insn_o      = insn_r;

    // A response must always have a request to belong to.
    rsp_has_owner_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> ((alloc_r != CNT_ZERO) || (drop_r != CNT_ZERO)));

    // Allocated plus to-be-dropped entries never exceed the queue.
    occupancy_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ({1'b0, alloc_r} + {1'b0, drop_r}) <= DEPTH_W);

endmodule

// File: tb/tb_rv0_fetch.sv
// Self-checking bench for rv0_fetch: a hand-computed vector table for the
// streaming/stall behaviour, then scenario sequences driven by a small
// in-order memory model and an address/instruction scoreboard.
module tb_rv0_fetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] K     = 32'hA5A5_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic [31:0] flush_addr;
    logic        req;
    logic [31:0] iaddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] addr_o;
    logic [31:0] insn_o;
    logic        rdy;
    logic        ack;

    logic        flush2, gnt2, rvalid2, ack2;
    logic [31:0] flush_addr2, rdata2;
    logic        req2, rdy2;
    logic [31:0] iaddr2, addr2_o, insn2_o;

    rv0_fetch u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_addr_i(flush_addr),
        .imem_req_o(req), .imem_addr_o(iaddr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .addr_o(addr_o), .insn_o(insn_o), .rdy_o(rdy), .ack_i(ack)
    );

    rv0_fetch #(.RESET_ADDR(32'hFFFF_FFF8)) u_dut_wrap (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush2), .flush_addr_i(flush_addr2),
        .imem_req_o(req2), .imem_addr_o(iaddr2), .imem_gnt_i(gnt2),
        .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
        .addr_o(addr2_o), .insn_o(insn2_o), .rdy_o(rdy2), .ack_i(ack2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_iaddr;
        logic        exp_rdy;
        logic [31:0] exp_addr;
        logic [31:0] exp_insn;
    } vec_t;

    vec_t        vt [16];
    logic [31:0] wrap_exp [5];

    // memory model and scoreboard state
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    int          cyc;
    int          lat;
    int          gnt_mode;   // 0: always, 1: random, 2: never
    int          ack_mode;   // 0: always, 1: random, 2: never
    logic [31:0] exp_next;
    int          pops;
    int          tb_alloc;
    int          stale;

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0; flush_addr = 32'h0; gnt = 1'b0; rvalid = 1'b0;
        rdata = 32'h0; ack = 1'b0;
        mq_addr.delete(); mq_due.delete();
        repeat (2) @(negedge clk);
        chk("reset_req", {31'h0, req}, 32'h0);
        chk("reset_rdy", {31'h0, rdy}, 32'h0);
        chk("reset_insn", insn_o, 32'h13);
        rst_n = 1'b1;
        cyc = 0; exp_next = 32'h0; tb_alloc = 0; stale = 0;
    endtask

    // One model-driven cycle; entered and left at the falling edge.
    task automatic step(input logic fl, input logic [31:0] fa);
        logic        g, a, rv, granted;
        logic [31:0] rd, ga;
        rv = 1'b0;
        rd = 32'h13;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            rv = 1'b1;
            rd = mq_addr[0] ^ K;
        end
        g = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        a = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        gnt = g; ack = a; rvalid = rv; rdata = rd; flush = fl; flush_addr = fa;
        #1;
        if (rdy) begin
            chk("head_addr", addr_o, exp_next);
            chk("head_insn", insn_o, exp_next ^ K);
        end
        granted = req & g;
        ga = iaddr;
        @(posedge clk);
        if (granted) begin
            mq_addr.push_back(ga);
            mq_due.push_back(cyc + lat);
        end
        if (rv) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (fl) begin
            stale    = mq_addr.size();
            tb_alloc = 0;
            exp_next = {fa[31:2], 2'b00};
        end else begin
            if (rv && stale > 0) stale--;
            if (granted) tb_alloc++;
            if (rdy && a) begin
                tb_alloc--;
                exp_next = exp_next + 32'd4;
                pops++;
            end
        end
        cyc++;
        @(negedge clk);
        flush = 1'b0;
        chk("occupancy", {31'h0, (tb_alloc + stale <= DEPTH)}, 32'h1);
    endtask

    initial begin
        // streaming from reset, then a 4-cycle stall filling the queue
        vt[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h13};
        vt[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h13};
        vt[2]  = '{1'b1, 1'b1, 32'hA5A5_0000, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'hA5A5_0000};
        vt[3]  = '{1'b1, 1'b1, 32'hA5A5_0004, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'hA5A5_0004};
        vt[4]  = '{1'b1, 1'b1, 32'hA5A5_0008, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'hA5A5_0008};
        vt[5]  = '{1'b1, 1'b1, 32'hA5A5_000C, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 32'hA5A5_000C};
        vt[6]  = '{1'b1, 1'b1, 32'hA5A5_0010, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10, 32'hA5A5_0010};
        vt[7]  = '{1'b1, 1'b1, 32'hA5A5_0014, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10, 32'hA5A5_0010};
        vt[8]  = '{1'b1, 1'b1, 32'hA5A5_0018, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 32'hA5A5_0010};
        vt[9]  = '{1'b1, 1'b1, 32'hA5A5_001C, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 32'hA5A5_0010};
        vt[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 32'hA5A5_0010};
        vt[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h20, 1'b1, 32'h14, 32'hA5A5_0014};
        vt[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h24, 1'b1, 32'h18, 32'hA5A5_0018};
        vt[13] = '{1'b1, 1'b1, 32'hA5A5_0020, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C, 32'hA5A5_001C};
        vt[14] = '{1'b1, 1'b1, 32'hA5A5_0024, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h20, 32'hA5A5_0020};
        vt[15] = '{1'b0, 1'b1, 32'hA5A5_0028, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h24, 32'hA5A5_0024};
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;
        wrap_exp[4] = 32'h0000_0008;

        flush2 = 1'b0; flush_addr2 = 32'h0; gnt2 = 1'b1; rvalid2 = 1'b0;
        rdata2 = 32'h0; ack2 = 1'b0;
        pops = 0; lat = 1; gnt_mode = 0; ack_mode = 0;

        // ---- table phase ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            gnt = vt[i].gnt; rvalid = vt[i].rv; rdata = vt[i].rdata; ack = vt[i].ack;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_req", i),   {31'h0, req}, {31'h0, vt[i].exp_req});
            chk($sformatf("v%0d_iaddr", i), iaddr, vt[i].exp_iaddr);
            chk($sformatf("v%0d_rdy", i),   {31'h0, rdy}, {31'h0, vt[i].exp_rdy});
            chk($sformatf("v%0d_addr", i),  addr_o, vt[i].exp_addr);
            chk($sformatf("v%0d_insn", i),  insn_o, vt[i].exp_insn);
            if (i < 5) chk($sformatf("wrap%0d_iaddr", i), iaddr2, wrap_exp[i]);
            if (i == 4) chk("wrap_full_req", {31'h0, req2}, 32'h0);
            @(negedge clk);
        end

        // ---- flush with two late responses in flight ----
        do_reset();
        lat = 3; gnt_mode = 0; ack_mode = 0;
        repeat (3) step(1'b0, 32'h0);
        gnt_mode = 2;
        step(1'b1, 32'h0000_1003);
        chk("flA_iaddr", iaddr, 32'h0000_1000);
        chk("flA_req", {31'h0, req}, 32'h1);
        chk("flA_rdy", {31'h0, rdy}, 32'h0);
        gnt_mode = 0;
        begin
            int p0 = pops;
            for (int n = 0; n < 40 && pops < p0 + 4; n++) step(1'b0, 32'h0);
            chk("flA_progress", {31'h0, (pops >= p0 + 4)}, 32'h1);
        end

        // ---- flush with grant, rvalid and pop in the same cycle ----
        do_reset();
        lat = 1; gnt_mode = 0; ack_mode = 0;
        repeat (6) step(1'b0, 32'h0);
        chk("flB_pre_rdy", {31'h0, rdy}, 32'h1);
        step(1'b1, 32'h0000_2000);
        chk("flB_rdy0", {31'h0, rdy}, 32'h0);
        chk("flB_iaddr", iaddr, 32'h0000_2000);
        step(1'b0, 32'h0);
        chk("flB_rdy1", {31'h0, rdy}, 32'h0);
        begin
            int p0 = pops;
            for (int n = 0; n < 40 && pops < p0 + 6; n++) step(1'b0, 32'h0);
            chk("flB_progress", {31'h0, (pops >= p0 + 6)}, 32'h1);
        end

        // ---- random grant and ack ----
        do_reset();
        lat = 2; gnt_mode = 1; ack_mode = 1;
        begin
            int p0 = pops;
            for (int n = 0; n < 300; n++) step(1'b0, 32'h0);
            chk("rand_progress", {31'h0, (pops >= p0 + 30)}, 32'h1);
        end

        // ---- reset asserted mid-stream ----
        do_reset();
        lat = 1; gnt_mode = 0; ack_mode = 0;
        repeat (5) step(1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", {31'h0, rdy}, 32'h0);
        chk("midrst_insn", insn_o, 32'h13);
        chk("midrst_req", {31'h0, req}, 32'h0);
        chk("midrst_iaddr", iaddr, 32'h0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
